// File: rtl/mining_pkg.sv
// Shared definitions for the mining pipeline: Mining_FSM state encodings,
// datapath widths, message buffer sizing and the feeder state type.
package mining_pkg;

    localparam int MAX_BITS    = 30000;
    localparam int WORD_W      = 32;
    localparam int CHUNK_WORDS = 16;
    localparam int LEN_W       = 64;
    localparam int MAX_WORDS   = (MAX_BITS + WORD_W - 1) / WORD_W;
    localparam int PTR_W       = $clog2(MAX_WORDS + 1);
    localparam int IDX_W       = 7;

    // Mining_FSM state encodings; only ST_LOAD matters to the feeder.
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_LOAD  = 3'b001;
    localparam logic [2:0] ST_PREP  = 3'b010;
    localparam logic [2:0] ST_HASH  = 3'b011;
    localparam logic [2:0] ST_CHECK = 3'b100;
    localparam logic [2:0] ST_FOUND = 3'b101;

    typedef enum logic [2:0] {
        FEED_EMPTY,
        FEED_FILL,
        FEED_READY,
        FEED_STREAM,
        FEED_DONE
    } feed_state_e;

    // Keeps the low 'bits' bits of a right-aligned partial last word.
    function automatic logic [WORD_W-1:0] last_word_mask(input logic [5:0] bits);
        if (bits >= 6'd32) begin
            return {WORD_W{1'b1}};
        end
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/msg_word_buffer.sv
// Message word store: synchronous write, asynchronous read, so the replay
// path can register a fresh word on every load cycle without bubbles.
module msg_word_buffer #(
    parameter int DEPTH = 938,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write port: one word per accepted handshake.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/message_feeder.sv
// message_feeder: accepts the block message over valid/ready, stores it,
// and replays it word by word to Preprocessing while Mining_FSM is in its
// load state. The stored message survives reset_fsm so each nonce attempt
// replays it without reloading.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// FEED_EMPTY  | no message; waiting for the first word
// FEED_FILL   | collecting words until in_last (stalls when buffer full)
// FEED_READY  | message stored, start=1, replay pointers at zero
// FEED_STREAM | issuing one word per load-state cycle
// FEED_DONE   | last word issued, stopw=1, waiting for reset_fsm
module message_feeder
    import mining_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [5:0]  in_last_bits,
    input  logic        clear,
    input  logic [2:0]  state,
    input  logic        reset_fsm,
    output logic [31:0] message,
    output logic [6:0]  indirizzo,
    output logic [63:0] mess_lenght,
    output logic        start,
    output logic        stopw,
    output logic        overflow
);

    feed_state_e       fsm_q, fsm_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  last_idx_q, last_idx_d;
    logic [WORD_W-1:0] message_q, message_d;
    logic [IDX_W-1:0]  indirizzo_q, indirizzo_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              start_q, start_d;
    logic              stopw_q, stopw_d;
    logic              ovf_q, ovf_d;
    logic              alive_q;

    logic              load;
    logic              hs;
    logic              bad_last;
    logic              wr_full;
    logic              last_issue;
    logic              buf_we;
    logic [WORD_W-1:0] buf_wdata;
    logic [WORD_W-1:0] buf_rdata;

    assign load       = (state == ST_LOAD);
    assign wr_full    = (wr_ptr_q == PTR_W'(MAX_WORDS));
    assign in_ready   = alive_q && ((fsm_q == FEED_EMPTY) ||
                                    ((fsm_q == FEED_FILL) && !wr_full));
    assign hs         = in_valid && in_ready;
    assign bad_last   = (in_last_bits == 6'd0) || (in_last_bits > 6'd32);
    assign last_issue = (rd_ptr_q == last_idx_q);
    assign buf_we     = hs && !clear;
    assign buf_wdata  = in_last ? (in_data & last_word_mask(in_last_bits)) : in_data;

    msg_word_buffer #(
        .DEPTH (MAX_WORDS),
        .AW    (PTR_W),
        .DW    (WORD_W)
    ) u_buf (
        .clock   (clock),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (buf_wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (buf_rdata)
    );

    // in_ready is held low until the first edge after reset is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    // Feeder state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q <= FEED_EMPTY;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic; clear overrides every transition.
    always_comb begin
        fsm_d = fsm_q;
        if (clear) begin
            fsm_d = FEED_EMPTY;
        end else begin
            case (fsm_q)
                FEED_EMPTY: begin
                    if (hs) begin
                        if (!in_last)     fsm_d = FEED_FILL;
                        else if (!bad_last) fsm_d = FEED_READY;
                    end
                end
                FEED_FILL: begin
                    if (hs && in_last) begin
                        fsm_d = bad_last ? FEED_EMPTY : FEED_READY;
                    end
                end
                FEED_READY: begin
                    if (load) begin
                        fsm_d = last_issue ? FEED_DONE : FEED_STREAM;
                    end
                end
                FEED_STREAM: begin
                    if (reset_fsm) begin
                        fsm_d = FEED_READY;
                    end else if (load && last_issue) begin
                        fsm_d = FEED_DONE;
                    end
                end
                FEED_DONE: begin
                    if (reset_fsm) begin
                        fsm_d = FEED_READY;
                    end
                end
                default: fsm_d = FEED_EMPTY;
            endcase
        end
    end

    // Datapath next values: write pointer, replay pointer and registered outputs.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_idx_d  = last_idx_q;
        message_d   = message_q;
        indirizzo_d = indirizzo_q;
        len_d       = len_q;
        start_d     = start_q;
        stopw_d     = stopw_q;
        ovf_d       = ovf_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            message_d   = '0;
            indirizzo_d = '0;
            len_d       = '0;
            start_d     = 1'b0;
            stopw_d     = 1'b0;
        end else begin
            case (fsm_q)
                FEED_EMPTY, FEED_FILL: begin
                    if ((fsm_q == FEED_FILL) && in_valid && wr_full) begin
                        ovf_d = 1'b1;
                    end
                    if (hs) begin
                        if (!in_last) begin
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        end else if (bad_last) begin
                            ovf_d    = 1'b1;
                            wr_ptr_d = '0;
                        end else begin
                            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                            last_idx_d  = wr_ptr_q;
                            len_d       = LEN_W'({wr_ptr_q, 5'b00000}) + LEN_W'(in_last_bits);
                            rd_ptr_d    = '0;
                            indirizzo_d = '0;
                            start_d     = 1'b1;
                            stopw_d     = 1'b0;
                        end
                    end
                end
                FEED_READY, FEED_STREAM: begin
                    if ((fsm_q == FEED_STREAM) && reset_fsm) begin
                        rd_ptr_d    = '0;
                        indirizzo_d = '0;
                        start_d     = 1'b1;
                        stopw_d     = 1'b0;
                    end else if (load) begin
                        message_d = buf_rdata;
                        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                        if (rd_ptr_q[3:0] == 4'(CHUNK_WORDS - 1)) begin
                            indirizzo_d = indirizzo_q + IDX_W'(1);
                        end
                        if (last_issue) begin
                            start_d = 1'b0;
                            stopw_d = 1'b1;
                        end
                    end
                end
                FEED_DONE: begin
                    if (reset_fsm) begin
                        rd_ptr_d    = '0;
                        indirizzo_d = '0;
                        start_d     = 1'b1;
                        stopw_d     = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_idx_q  <= '0;
            message_q   <= '0;
            indirizzo_q <= '0;
            len_q       <= '0;
            start_q     <= 1'b0;
            stopw_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_idx_q  <= last_idx_d;
            message_q   <= message_d;
            indirizzo_q <= indirizzo_d;
            len_q       <= len_d;
            start_q     <= start_d;
            stopw_q     <= stopw_d;
            ovf_q       <= ovf_d;
        end
    end

    assign message     = message_q;
    assign indirizzo   = indirizzo_q;
    assign mess_lenght = len_q;
    assign start       = start_q;
    assign stopw       = stopw_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_message_feeder.sv
// Bench for message_feeder: table of load scenarios, hand-written multi-cycle
// corner cases, and randomized load/replay checked against a word-queue model.
module tb_message_feeder;
    import mining_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [5:0]  in_last_bits;
    logic        clear;
    logic [2:0]  state;
    logic        reset_fsm;
    logic [31:0] message;
    logic [6:0]  indirizzo;
    logic [63:0] mess_lenght;
    logic        start;
    logic        stopw;
    logic        overflow;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the message as the feeder should replay it.
    logic [31:0] model_q [$];

    typedef struct {
        int          nwords;
        int          lastbits;
        logic [63:0] exp_len;
        logic        exp_ovf;
        logic        exp_start;
        logic        exp_ready;
    } load_vec_t;

    load_vec_t tbl [8];

    always #5 clock = ~clock;

    message_feeder dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_last_bits (in_last_bits),
        .clear        (clear),
        .state        (state),
        .reset_fsm    (reset_fsm),
        .message      (message),
        .indirizzo    (indirizzo),
        .mess_lenght  (mess_lenght),
        .start        (start),
        .stopw        (stopw),
        .overflow     (overflow)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        in_last_bits = '0;
        clear        = 1'b0;
        state        = ST_IDLE;
        reset_fsm    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Streams a message of nwords words; the model keeps the masked image.
    task automatic load_msg(input int nwords, input int lastbits, input int gap_pct);
        logic [31:0] d;
        logic [63:0] kept;
        int          budget;
        model_q.delete();
        for (int i = 0; i < nwords; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                tick();
            end
            d            = $urandom;
            in_valid     = 1'b1;
            in_data      = d;
            in_last      = (i == nwords - 1);
            in_last_bits = (i == nwords - 1) ? 6'(lastbits) : 6'($urandom_range(63));
            budget = 0;
            while (!in_ready && budget < 20) begin
                tick();
                budget++;
            end
            if (!in_ready) begin
                fail_now("load_ready");
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            tick();
            if (i == nwords - 1 && lastbits < 32) kept = 64'(d) % (64'd1 << lastbits);
            else kept = 64'(d);
            model_q.push_back(kept[31:0]);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drives load cycles (with random non-load stalls) from k0 issued words
    // until k_end words are issued, checking every cycle.
    task automatic replay(input int k0, input int k_end, input int stall_pct);
        int   n;
        int   k;
        int   cyc;
        logic ld;
        n   = model_q.size();
        k   = k0;
        cyc = 0;
        while (k < k_end && cyc < 20 * n + 100) begin
            ld    = ($urandom_range(99) >= stall_pct);
            state = ld ? ST_LOAD : 3'($urandom_range(7, 2));
            tick();
            cyc++;
            if (ld) k++;
            if (k > 0) check("replay_message", 64'(message), 64'(model_q[k-1]));
            check("replay_indirizzo", 64'(indirizzo), 64'(k / 16));
            check("replay_start", 64'(start), 64'(k < n));
            check("replay_stopw", 64'(stopw), 64'(k == n));
        end
        state = ST_IDLE;
        if (k < k_end) fail_now("replay_budget");
    endtask

    task automatic pulse_reset_fsm();
        reset_fsm = 1'b1;
        tick();
        reset_fsm = 1'b0;
        check("rfsm_start", 64'(start), 64'd1);
        check("rfsm_stopw", 64'(stopw), 64'd0);
        check("rfsm_indirizzo", 64'(indirizzo), 64'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1,   1,  64'd1,     1'b0, 1'b1, 1'b0};
        tbl[1] = '{1,   32, 64'd32,    1'b0, 1'b1, 1'b0};
        tbl[2] = '{2,   5,  64'd37,    1'b0, 1'b1, 1'b0};
        tbl[3] = '{16,  32, 64'd512,   1'b0, 1'b1, 1'b0};
        tbl[4] = '{32,  8,  64'd1000,  1'b0, 1'b1, 1'b0};
        tbl[5] = '{938, 16, 64'd30000, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{3,   0,  64'd0,     1'b1, 1'b0, 1'b1};
        tbl[7] = '{2,   40, 64'd0,     1'b1, 1'b0, 1'b1};

        // Reset values, both while held and on the first cycle after.
        idle_inputs();
        reset = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_message", 64'(message), 64'd0);
        check("rst_indirizzo", 64'(indirizzo), 64'd0);
        check("rst_len", mess_lenght, 64'd0);
        check("rst_start", 64'(start), 64'd0);
        check("rst_stopw", 64'(stopw), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b1;
        tick();
        check("rst_ready_after", 64'(in_ready), 64'd1);

        // Table-driven load scenarios.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            load_msg(tbl[r].nwords, tbl[r].lastbits, 0);
            check("tbl_len", mess_lenght, tbl[r].exp_len);
            check("tbl_start", 64'(start), 64'(tbl[r].exp_start));
            check("tbl_overflow", 64'(overflow), 64'(tbl[r].exp_ovf));
            check("tbl_in_ready", 64'(in_ready), 64'(tbl[r].exp_ready));
            if (tbl[r].exp_start) replay(0, model_q.size(), 0);
        end

        // 1000-bit message: masking, hold in DONE, rewind, stall, second replay.
        do_reset();
        load_msg(32, 8, 0);
        check("m1000_len", mess_lenght, 64'd1000);
        replay(0, 32, 0);
        check("m1000_mask", 64'(message[31:8]), 64'd0);
        state = ST_LOAD;
        tick();
        state = ST_IDLE;
        check("done_hold_msg", 64'(message), 64'(model_q[31]));
        check("done_hold_stopw", 64'(stopw), 64'd1);
        check("done_hold_idx", 64'(indirizzo), 64'd2);
        pulse_reset_fsm();
        replay(0, 20, 0);
        for (int s = 0; s < 5; s++) begin
            state = 3'(s + 2);
            tick();
            check("stall_message", 64'(message), 64'(model_q[19]));
            check("stall_indirizzo", 64'(indirizzo), 64'd1);
            check("stall_start", 64'(start), 64'd1);
        end
        replay(20, 32, 0);
        pulse_reset_fsm();
        replay(0, 32, 40);

        // reset_fsm in STREAM wins over a simultaneous load cycle.
        pulse_reset_fsm();
        replay(0, 5, 0);
        state = ST_LOAD;
        pulse_reset_fsm();
        state = ST_IDLE;
        replay(0, 32, 0);

        // Asynchronous reset in the middle of a replay.
        pulse_reset_fsm();
        replay(0, 20, 0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_message", 64'(message), 64'd0);
        check("arst_indirizzo", 64'(indirizzo), 64'd0);
        check("arst_start", 64'(start), 64'd0);
        check("arst_stopw", 64'(stopw), 64'd0);
        check("arst_len", mess_lenght, 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        idle_inputs();
        #20;
        reset = 1'b1;
        tick();
        check("arst_ready_after", 64'(in_ready), 64'd1);
        state = ST_LOAD;
        repeat (3) tick();
        state = ST_IDLE;
        check("arst_no_start", 64'(start), 64'd0);
        check("arst_no_msg", 64'(message), 64'd0);

        // clear colliding with a word: word dropped, fresh load is intact.
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_in_ready", 64'(in_ready), 64'd1);
        load_msg(2, 20, 0);
        check("clr_len", mess_lenght, 64'd52);
        replay(0, 2, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_done_start", 64'(start), 64'd0);
        check("clr_done_stopw", 64'(stopw), 64'd0);
        check("clr_done_len", mess_lenght, 64'd0);
        check("clr_done_ready", 64'(in_ready), 64'd1);

        // Overflow: 939th word without in_last.
        do_reset();
        for (int i = 0; i < 938; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'b0;
            tick();
        end
        check("ovf_ready_full", 64'(in_ready), 64'd0);
        check("ovf_before", 64'(overflow), 64'd0);
        tick();
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_ready_stuck", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        check("ovf_clear_ready", 64'(in_ready), 64'd1);
        check("ovf_sticky", 64'(overflow), 64'd1);
        load_msg(3, 32, 0);
        check("ovf_reload_start", 64'(start), 64'd1);
        check("ovf_still", 64'(overflow), 64'd1);
        replay(0, 3, 0);
        do_reset();
        check("ovf_reset", 64'(overflow), 64'd0);

        // Randomized messages, each replayed twice, separated by clear.
        for (int m = 0; m < 8; m++) begin
            int nw;
            int lb;
            nw = $urandom_range(40, 1);
            lb = $urandom_range(32, 1);
            load_msg(nw, lb, 30);
            check("rnd_len", mess_lenght, 64'(32 * (nw - 1) + lb));
            check("rnd_start", 64'(start), 64'd1);
            replay(0, nw, 30);
            pulse_reset_fsm();
            replay(0, nw, 30);
            clear = 1'b1;
            tick();
            clear = 1'b0;
            check("rnd_clear_ready", 64'(in_ready), 64'd1);
        end
        check("rnd_no_overflow", 64'(overflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/message_feeder.md
# message_feeder

Upstream stage of the mining pipeline. Accepts the block message as a stream of 32-bit words over a valid/ready handshake and holds it in an internal word buffer. It then replays it word by word into `Preprocessing` while `Mining_FSM` is in its load state, driving `message`, `indirizzo`, `mess_lenght`, `start` and `stopw`. The buffer is retained across `reset_fsm`, so every nonce attempt replays the same message without reloading.

## Interface
- `MAX_BITS`, 30000: maximum message length in bits.
- `MAX_WORDS`, ceil(`MAX_BITS`/32) = 938: buffer depth in words (derived).
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state and empties the buffer.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: feeder can accept a word.
- `in_data` input 32: message word, MSB-first order. A partial last word is right-aligned.
- `in_last` input 1: marks the final word of the message.
- `in_last_bits` input 6: valid bits in the final word, 1..32; sampled only with `in_last`.
- `clear` input 1: synchronous; drops the stored message and returns to EMPTY.
- `state` input 3: `Mining_FSM` state; 3'b001 = load.
- `reset_fsm` input 1: pulse from `Mining_FSM`; rewinds replay.
- `message` output 32: word presented to `Preprocessing`.
- `indirizzo` output 7: 512-bit chunk index of the word stream.
- `mess_lenght` output 64: message length in bits.
- `start` output 1: message available for mining.
- `stopw` output 1: final word has been issued.
- `overflow` output 1: sticky; message exceeded `MAX_BITS` or had a bad `in_last_bits`.

## Operation
- States:
  - EMPTY: initial state.
    - `in_ready`=1. First accepted word goes to FILL; if that word carries `in_last`, go directly to READY.
  - FILL:
    - `in_ready`=1 while `wr_ptr` < `MAX_WORDS`.
    - Each handshake (`in_valid`&&`in_ready`) writes `buf[wr_ptr]` and increments `wr_ptr`.
    - Handshake with `in_last` goes to READY.
    - Length is 32·(`wr_ptr`) + `in_last_bits`, where `wr_ptr` is the pre-increment count.
  - READY:
    - `in_ready`=0, `start`=1, `rd_ptr`=0, `indirizzo`=0.
    - First cycle with `state`==3'b001 goes to STREAM.
  - STREAM: on each posedge where `state`==3'b001:
    - `message` <= `buf[rd_ptr]`; `rd_ptr`++.
    - After 16 issued words, `indirizzo`++ (i.e., when `rd_ptr`[3:0] wraps to 0).
    - When the issued word is word `total_words`−1: `start` <= 0, `stopw` <= 1, go to DONE.
    - If `state`≠001, hold all outputs.
  - DONE:
    - `message` holds the last word; `stopw`=1.
    - `reset_fsm` goes to READY: `start`=1, `stopw`=0, pointers 0. Buffer is kept.
- `total_words` = ceil(`mess_lenght`/32). The last word keeps its low `mess_lenght`%32 bits; upper bits are forced to 0. If `mess_lenght`%32==0, the word is full.
- Overflow conditions:
  - A word offered when `wr_ptr`==`MAX_WORDS` without `in_last`: `in_ready` stays 0, `overflow`=1, FSM stays in FILL until `clear` or `reset`.
  - `in_last_bits`==0 or >32: `overflow`=1, state goes to EMPTY.
- `clear` has priority over every transition except `reset`. `reset_fsm` outside DONE/STREAM is ignored; in STREAM it rewinds to READY.

## Timing
- Reset values: `in_ready`=0 during reset, 1 on the first cycle after; `message`=0, `indirizzo`=0, `mess_lenght`=0, `start`=0, `stopw`=0, `overflow`=0, state EMPTY.
- `start` rises on the cycle after the `in_last` handshake.
- `message` is registered: the word is visible one cycle after the posedge that sampled `state`==001. A message of N words needs N load-state cycles.
- The buffer uses asynchronous read (distributed/register array), so there are no replay bubbles.
- `stopw` and `start` change on the same edge that issues the final word.
- Simultaneous `in_valid` and `clear`: `clear` wins and the word is dropped.

## Structure
- Shared package `mining_pkg`:
  - `ST_LOAD`=3'b001 and the other `Mining_FSM` state encodings.
  - `WORD_W`=32, `CHUNK_WORDS`=16, `LEN_W`=64.
  - Feeder state typedef.
- One sub-module, `msg_word_buffer`: dual-port array (synchronous write, asynchronous read) of depth `MAX_WORDS`.

## Test plan
- Load 1000-bit message (31 full words + last word, `in_last_bits`=8) → `mess_lenght`=1000, `start`=1. Replay issues 32 words in 32 load cycles. `indirizzo` steps 0→1 after word 16. Last `message` upper 24 bits are 0; `stopw`=1.
- Load 512-bit message (16 words, last full) → `stopw` on word 16, `indirizzo` increments to 1 on the 16th word, no zero-masking.
- Pulse `reset_fsm` after DONE → `start`=1, `stopw`=0. Second replay is bit-identical to the first, with no input handshakes.
- Drop `state` from 001 for 5 cycles mid-stream → `message`, `rd_ptr` and `indirizzo` frozen; replay resumes without word loss.
- Offer 939 words without `in_last` (`MAX_BITS`=30000) → `in_ready`=0 at word 939, `overflow`=1. `clear` → EMPTY, `overflow` stays set until `reset`.
- Assert `reset` low mid-STREAM → all outputs at reset values immediately (asynchronous). Buffer empty; `start`=0 until a new load.
